// File: rtl/axis_pack_pkg.sv
// Shared sizing helpers, default parameters and legality checks for the AXIS row-packing FIFO.
package axis_pack_pkg;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

    function automatic int calc_epb(input int data_w, input int elem_w);
        return data_w / elem_w;
    endfunction

    // One spare bit above the largest idx+EPB sum keeps the commit compare overflow-free.
    function automatic int calc_idx_w(input int mac_num, input int epb);
        return clog2(mac_num + epb) + 1;
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    function automatic bit params_legal(input int data_w, input int elem_w, input int depth);
        return is_pow2(depth) && (depth >= 2) && (calc_epb(data_w, elem_w) >= 1);
    endfunction

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ELEM_W  = 5;
    localparam int DEF_MAC_NUM = 256;
    localparam int DEF_DEPTH   = 4;
    localparam int DEF_CH_W    = 12;
    localparam int DEF_EPB     = calc_epb(DEF_DATA_W, DEF_ELEM_W);
    localparam int DEF_IDX_W   = calc_idx_w(DEF_MAC_NUM, DEF_EPB);
    localparam int DEF_CNT_W   = calc_cnt_w(DEF_DEPTH);

    typedef enum logic [1:0] {
        CNT_HOLD,
        CNT_INC,
        CNT_DEC
    } cnt_op_e;

endpackage

// File: rtl/axis_pack_fifo_if.sv
// AXI-Stream beat channel feeding the row-packing FIFO.
interface axis_pack_fifo_if
    import axis_pack_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_pack_row_assembler.sv
// Tracks the fill position of the row being built and turns each accepted beat into
// per-element write enables, write data and a commit strobe for the slot store.
module axis_pack_row_assembler
    import axis_pack_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ELEM_W  = DEF_ELEM_W,
    parameter int MAC_NUM = DEF_MAC_NUM,
    parameter int CH_W    = DEF_CH_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear,
    input  logic                      acc,
    input  logic [DATA_W-1:0]         tdata,
    input  logic                      tlast,
    input  logic [CH_W-1:0]           cfg_channels,
    output logic [MAC_NUM-1:0]        wr_mask,
    output logic [ELEM_W*MAC_NUM-1:0] wr_data,
    output logic                      commit
);
    localparam int EPB   = calc_epb(DATA_W, ELEM_W);
    localparam int IDX_W = calc_idx_w(MAC_NUM, EPB);

    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   lim_q;
    logic [IDX_W-1:0]   cfg_lim;
    logic [IDX_W-1:0]   eff_lim;
    logic [MAC_NUM-1:0] written;
    logic               first_beat;
    logic               unused_tdata;

    // Bits above the last whole element are never part of a row.
    assign unused_tdata = ^tdata;
    assign first_beat   = (idx_q == '0);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cfg_lim = IDX_W'(MAC_NUM);
        if (cfg_channels != '0 && int'(cfg_channels) <= MAC_NUM) begin
            cfg_lim = IDX_W'(cfg_channels);
        end
        eff_lim = first_beat ? cfg_lim : lim_q;

        written = '0;
        wr_data = '0;
        for (int e = 0; e < MAC_NUM; e++) begin
            for (int k = 0; k < EPB; k++) begin
                if ((int'(idx_q) + k == e) && (e < int'(eff_lim))) begin
                    written[e]                   = 1'b1;
                    wr_data[e*ELEM_W +: ELEM_W]  = tdata[k*ELEM_W +: ELEM_W];
                end
            end
        end

        // The first beat of a row owns the whole slot, so unwritten elements become zero padding.
        wr_mask = '0;
        if (acc) begin
            wr_mask = first_beat ? '1 : written;
        end

        commit = acc && ((idx_q + IDX_W'(EPB) >= eff_lim) || tlast);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            lim_q <= '0;
        end else if (clear) begin
            idx_q <= '0;
        end else if (acc) begin
            if (first_beat) begin
                lim_q <= cfg_lim;
            end
            idx_q <= commit ? '0 : idx_q + IDX_W'(EPB);
        end
    end

endmodule

// File: rtl/axis_pack_fifo.sv
// Packs AXIS elements into MAC-array rows and buffers up to DEPTH committed rows
// for the MAC ifmap port; partial rows stay invisible until they commit.
module axis_pack_fifo
    import axis_pack_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ELEM_W   = DEF_ELEM_W,
    parameter int MAC_NUM  = DEF_MAC_NUM,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int CH_W     = DEF_CH_W,
    parameter int AF_LEVEL = DEPTH - 1
) (
    input  logic                      clk,
    input  logic                      rst,
    axis_pack_fifo_if.slave           s_axis,
    input  logic [CH_W-1:0]           cfg_channels,
    input  logic                      clear,
    input  logic                      rd_en,
    output logic [ELEM_W*MAC_NUM-1:0] rd_data,
    output logic                      rd_valid,
    output logic [clog2(DEPTH):0]     count,
    output logic                      empty,
    output logic                      full,
    output logic                      almost_full
);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam int PTR_W = clog2(DEPTH);
    localparam int ROW_W = ELEM_W * MAC_NUM;

    if (!params_legal(DATA_W, ELEM_W, DEPTH)) begin : g_param_check
        $error("axis_pack_fifo: DEPTH must be a power of two >= 2 and DATA_W >= ELEM_W");
    end

    logic [ELEM_W-1:0]  slot_mem [DEPTH][MAC_NUM];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [MAC_NUM-1:0] wr_mask;
    logic [ROW_W-1:0]   wr_data;
    logic               commit;
    logic               pop;
    logic               tready;
    logic               acc;
    cnt_op_e            cnt_op;

    assign pop           = rd_en & ~empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a beat.
    assign tready        = ~rst & (~full | pop);
    assign s_axis.tready = tready;
    assign acc           = s_axis.tvalid & tready & ~clear;

    axis_pack_row_assembler #(
        .DATA_W  (DATA_W),
        .ELEM_W  (ELEM_W),
        .MAC_NUM (MAC_NUM),
        .CH_W    (CH_W)
    ) u_row_assembler (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .acc          (acc),
        .tdata        (s_axis.tdata),
        .tlast        (s_axis.tlast),
        .cfg_channels (cfg_channels),
        .wr_mask      (wr_mask),
        .wr_data      (wr_data),
        .commit       (commit)
    );

    // NOTE: row storage has no reset; only pointers and count define what is valid.
    always_ff @(posedge clk) begin
        for (int e = 0; e < MAC_NUM; e++) begin
            if (wr_mask[e]) begin
                slot_mem[wr_ptr][e] <= wr_data[e*ELEM_W +: ELEM_W];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int e = 0; e < MAC_NUM; e++) begin
            rd_data[e*ELEM_W +: ELEM_W] = slot_mem[rd_ptr][e];
        end
    end

    always_comb begin
        cnt_op = CNT_HOLD;
        if (commit && !pop) begin
            cnt_op = CNT_INC;
        end else if (pop && !commit) begin
            cnt_op = CNT_DEC;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (commit) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (cnt_op)
                CNT_INC: count <= count + 1'b1;
                CNT_DEC: count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign almost_full = (int'(count) >= AF_LEVEL);
    assign rd_valid    = ~empty;

endmodule

// File: tb/tb_axis_pack_fifo.sv
// Scenario bench for axis_pack_fifo: expected rows are queued as stimulus is driven
// and compared against rd_data when each row is popped.
module tb_axis_pack_fifo;
    import axis_pack_pkg::*;

    localparam int DATA_W  = 32;
    localparam int ELEM_W  = 5;
    localparam int MAC_NUM = 16;
    localparam int DEPTH   = 4;
    localparam int CH_W    = 12;
    localparam int EPB     = 6;
    localparam int ROW_W   = ELEM_W * MAC_NUM;

    logic             clk;
    logic             rst;
    logic [CH_W-1:0]  cfg_channels;
    logic             clear;
    logic             rd_en;
    logic [ROW_W-1:0] rd_data;
    logic             rd_valid;
    logic [2:0]       count;
    logic             empty;
    logic             full;
    logic             almost_full;

    int checks = 0;
    int errors = 0;
    logic [ROW_W-1:0] exp_q[$];

    axis_pack_fifo_if #(.DATA_W(DATA_W)) s_axis ();

    axis_pack_fifo #(
        .DATA_W  (DATA_W),
        .ELEM_W  (ELEM_W),
        .MAC_NUM (MAC_NUM),
        .DEPTH   (DEPTH),
        .CH_W    (CH_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis       (s_axis),
        .cfg_channels (cfg_channels),
        .clear        (clear),
        .rd_en        (rd_en),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Beat carrying elements start..start+5; the two spare top bits are set to show they are ignored.
    function automatic logic [DATA_W-1:0] beat_data(input int start);
        logic [DATA_W-1:0] d;
        d = '1;
        for (int k = 0; k < EPB; k++) d[k*ELEM_W +: ELEM_W] = ELEM_W'(start + k);
        return d;
    endfunction

    // Row whose elements 0..n-1 are start..start+n-1 followed by zero padding.
    function automatic logic [ROW_W-1:0] make_row(input int start, input int n);
        logic [ROW_W-1:0] r;
        r = '0;
        for (int e = 0; e < MAC_NUM; e++) begin
            if (e < n) r[e*ELEM_W +: ELEM_W] = ELEM_W'(start + e);
        end
        return r;
    endfunction

    // Drives one beat from a negedge and returns at the negedge after it was accepted.
    task automatic send_beat(input int start, input bit last);
        int waited;
        waited = 0;
        s_axis.tdata  = beat_data(start);
        s_axis.tvalid = 1'b1;
        s_axis.tlast  = last;
        #1;
        while (s_axis.tready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checks++;
        if (waited >= 20) begin
            errors++;
            $display("FAIL beat_accept: tready stayed %b, required 1 within 20 cycles", s_axis.tready);
        end
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [ROW_W-1:0] exp;
        checks++;
        if (rd_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_valid: rd_valid=%b required 1", name, rd_valid);
        end
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_data: no expected row queued", name);
        end else begin
            exp = exp_q.pop_front();
            if (rd_data !== exp) begin
                errors++;
                $display("FAIL %s_data: rd_data=%h required %h", name, rd_data, exp);
            end
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({count, empty, full, almost_full, rd_valid, s_axis.tready} !== {3'd0, 5'b10000}) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b af=%b rd_valid=%b tready=%b required 0 1 0 0 0 0",
                     count, empty, full, almost_full, rd_valid, s_axis.tready);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_tready: tready=%b required 1", s_axis.tready);
        end
    endtask

    task automatic test_full_row();
        cfg_channels = 12'd16;
        exp_q.push_back(make_row(1, 16));
        send_beat(1, 1'b0);
        send_beat(7, 1'b0);
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL full_row_partial_count: count=%0d required 0", count);
        end
        send_beat(13, 1'b0);
        checks++;
        if (count !== 3'd1 || empty !== 1'b0) begin
            errors++;
            $display("FAIL full_row_commit_count: count=%0d empty=%b required 1 0", count, empty);
        end
        pop_check("full_row");
    endtask

    task automatic test_channel_limit();
        cfg_channels = 12'd8;
        exp_q.push_back(make_row(1, 8));
        send_beat(1, 1'b0);
        // The limit is latched on the first beat, so this change must not widen the row.
        cfg_channels = 12'd16;
        send_beat(7, 1'b0);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL channel_limit_count: count=%0d required 1", count);
        end
        pop_check("channel_limit");
    endtask

    task automatic test_tlast();
        cfg_channels = 12'd16;
        exp_q.push_back(make_row(1, 6));
        send_beat(1, 1'b1);
        exp_q.push_back(make_row(10, 16));
        send_beat(10, 1'b0);
        send_beat(16, 1'b0);
        send_beat(22, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL tlast_count: count=%0d required 2", count);
        end
        pop_check("tlast_short");
        pop_check("tlast_next");
    endtask

    task automatic test_full_wrap();
        logic [ROW_W-1:0] exp;
        cfg_channels = 12'd0;
        for (int r = 0; r < DEPTH; r++) begin
            exp_q.push_back(make_row(1 + 6 * r, 6));
            send_beat(1 + 6 * r, 1'b1);
            if (r == 1) begin
                checks++;
                if (almost_full !== 1'b0) begin
                    errors++;
                    $display("FAIL af_below: almost_full=%b required 0 at count %0d", almost_full, count);
                end
            end
            if (r == 2) begin
                checks++;
                if (almost_full !== 1'b1 || full !== 1'b0) begin
                    errors++;
                    $display("FAIL af_level: almost_full=%b full=%b required 1 0", almost_full, full);
                end
            end
        end
        checks++;
        if (count !== 3'd4 || full !== 1'b1 || s_axis.tready !== 1'b0) begin
            errors++;
            $display("FAIL full_state: count=%0d full=%b tready=%b required 4 1 0", count, full, s_axis.tready);
        end
        s_axis.tdata  = beat_data(25);
        s_axis.tvalid = 1'b1;
        s_axis.tlast  = 1'b1;
        rd_en         = 1'b1;
        #1;
        checks++;
        if (s_axis.tready !== 1'b1) begin
            errors++;
            $display("FAIL full_pop_tready: tready=%b required 1", s_axis.tready);
        end
        checks++;
        exp = exp_q.pop_front();
        if (rd_data !== exp) begin
            errors++;
            $display("FAIL full_pop_data: rd_data=%h required %h", rd_data, exp);
        end
        exp_q.push_back(make_row(25, 6));
        @(negedge clk);
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;
        rd_en         = 1'b0;
        checks++;
        if (count !== 3'd4 || full !== 1'b1) begin
            errors++;
            $display("FAIL pop_commit_count: count=%0d full=%b required 4 1", count, full);
        end
        for (int r = 0; r < DEPTH; r++) pop_check("wrap_drain");
        checks++;
        if (empty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL drained_empty: empty=%b rd_valid=%b required 1 0", empty, rd_valid);
        end
    endtask

    task automatic test_clear();
        cfg_channels = 12'd16;
        send_beat(2, 1'b1);
        send_beat(8, 1'b1);
        send_beat(14, 1'b0);
        checks++;
        if (count !== 3'd2) begin
            errors++;
            $display("FAIL clear_pre_count: count=%0d required 2", count);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++;
        if (count !== 3'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_state: count=%0d empty=%b rd_valid=%b required 0 1 0", count, empty, rd_valid);
        end
        exp_q.delete();
        exp_q.push_back(make_row(3, 16));
        send_beat(3, 1'b0);
        send_beat(9, 1'b0);
        send_beat(15, 1'b0);
        checks++;
        if (count !== 3'd1) begin
            errors++;
            $display("FAIL clear_refill_count: count=%0d required 1", count);
        end
        pop_check("clear_refill");
    endtask

    task automatic test_reset_mid_row();
        cfg_channels = 12'd16;
        send_beat(4, 1'b1);
        send_beat(10, 1'b1);
        send_beat(16, 1'b1);
        send_beat(22, 1'b0);
        checks++;
        if (count !== 3'd3 || almost_full !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_state: count=%0d af=%b required 3 1", count, almost_full);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({count, empty, full, almost_full, rd_valid, s_axis.tready} !== {3'd0, 5'b10000}) begin
            errors++;
            $display("FAIL async_reset_state: count=%0d empty=%b full=%b af=%b rd_valid=%b tready=%b required 0 1 0 0 0 0",
                     count, empty, full, almost_full, rd_valid, s_axis.tready);
        end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        exp_q.push_back(make_row(5, 16));
        send_beat(5, 1'b0);
        send_beat(11, 1'b0);
        send_beat(17, 1'b0);
        pop_check("post_reset");
        checks++;
        if (empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset_empty: empty=%b required 1", empty);
        end
    endtask

    initial begin
        rst           = 1'b1;
        clear         = 1'b0;
        rd_en         = 1'b0;
        cfg_channels  = 12'd16;
        s_axis.tdata  = '0;
        s_axis.tvalid = 1'b0;
        s_axis.tlast  = 1'b0;

        test_reset();
        test_full_row();
        test_channel_limit();
        test_tlast();
        test_full_wrap();
        test_clear();
        test_reset_mid_row();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
